// File: rtl/if_stage.sv
// Instruction-fetch stage: tracks the PC of an issued inst-bus request, waits for its
// data_ok, buffers the word across ID stalls and drops responses orphaned by a flush.
module if_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pfs_to_fs_valid,
    input  logic [XLEN-1:0] pfs_pc,
    input  logic            pfs_bd,
    output logic            fs_allowin,
    output logic            fs_valid,
    input  logic            inst_data_ok,
    input  logic [XLEN-1:0] inst_rdata,
    input  logic            ds_allowin,
    output logic            fs_to_ds_valid,
    output logic [XLEN-1:0] fs_to_ds_pc,
    output logic [XLEN-1:0] fs_to_ds_inst,
    output logic            fs_to_ds_bd,
    output logic            fs_to_ds_adel,
    input  logic            flush
);

    localparam int MAX_DISCARD = 2;

    logic            fs_valid_q, fs_valid_d;
    logic [XLEN-1:0] fs_pc_q, fs_pc_d;
    logic            fs_bd_q, fs_bd_d;
    logic [XLEN-1:0] inst_buf_q, inst_buf_d;
    logic            inst_buf_valid_q, inst_buf_valid_d;
    logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;

    logic             resp_live;
    logic             discard_hit;
    logic             fs_ready_go;
    logic             accept;
    logic             own_pending;
    logic [CNT_W:0]   cnt_sum;

    // A response is ours only once every orphaned response ahead of it has drained.
    assign resp_live   = inst_data_ok & (discard_cnt_q == '0);
    assign discard_hit = inst_data_ok & (discard_cnt_q != '0);
    assign fs_ready_go = inst_buf_valid_q | (fs_valid_q & resp_live);
    assign fs_allowin  = !fs_valid_q | (fs_ready_go & ds_allowin);
    assign accept      = pfs_to_fs_valid & fs_allowin & !flush;
    assign own_pending = fs_valid_q & !fs_ready_go;

    assign fs_valid       = fs_valid_q;
    assign fs_to_ds_valid = fs_valid_q & fs_ready_go & !flush;
    assign fs_to_ds_pc    = fs_pc_q;
    assign fs_to_ds_inst  = inst_buf_valid_q ? inst_buf_q : inst_rdata;
    assign fs_to_ds_bd    = fs_bd_q;
    assign fs_to_ds_adel  = fs_pc_q[1:0] != 2'b00;

    // Orphans created by a flush: our own unanswered request plus one issued this cycle.
    assign cnt_sum = {1'b0, discard_cnt_q}
                   + {{CNT_W{1'b0}}, own_pending}
                   + {{CNT_W{1'b0}}, pfs_to_fs_valid}
                   - {{CNT_W{1'b0}}, discard_hit};

    always_comb begin
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        fs_bd_d          = fs_bd_q;
        inst_buf_d       = inst_buf_q;
        inst_buf_valid_d = inst_buf_valid_q;
        discard_cnt_d    = discard_cnt_q;

        if (flush) begin
            fs_valid_d       = 1'b0;
            inst_buf_valid_d = 1'b0;
            discard_cnt_d    = cnt_sum[CNT_W-1:0];
        end else begin
            discard_cnt_d = discard_cnt_q - {{(CNT_W-1){1'b0}}, discard_hit};
            if (accept) begin
                fs_valid_d       = 1'b1;
                fs_pc_d          = pfs_pc;
                fs_bd_d          = pfs_bd;
                inst_buf_valid_d = 1'b0;
            end else if (fs_ready_go && ds_allowin) begin
                fs_valid_d       = 1'b0;
                inst_buf_valid_d = 1'b0;
            end else if (fs_valid_q && resp_live && !inst_buf_valid_q && !ds_allowin) begin
                inst_buf_d       = inst_rdata;
                inst_buf_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= '0;
            fs_bd_q          <= 1'b0;
            inst_buf_valid_q <= 1'b0;
            discard_cnt_q    <= '0;
        end else begin
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            fs_bd_q          <= fs_bd_d;
            inst_buf_valid_q <= inst_buf_valid_d;
            discard_cnt_q    <= discard_cnt_d;
        end
        inst_buf_q <= inst_buf_d;
    end

    // The bus allows at most two outstanding responses, so more orphans is a design error.
    always_ff @(posedge clk) begin
        if (!reset && flush) begin
            assert (int'(cnt_sum) <= MAX_DISCARD);
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected ID deliveries are queued as responses are driven
// and compared whenever the DUT completes a handshake with ID.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        bd;
        logic        adel;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        pfs_to_fs_valid;
    logic [31:0] pfs_pc;
    logic        pfs_bd;
    logic        fs_allowin;
    logic        fs_valid;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_pc;
    logic [31:0] fs_to_ds_inst;
    logic        fs_to_ds_bd;
    logic        fs_to_ds_adel;
    logic        flush;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    if_stage #(.XLEN(32), .CNT_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .pfs_to_fs_valid(pfs_to_fs_valid),
        .pfs_pc         (pfs_pc),
        .pfs_bd         (pfs_bd),
        .fs_allowin     (fs_allowin),
        .fs_valid       (fs_valid),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .ds_allowin     (ds_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_pc    (fs_to_ds_pc),
        .fs_to_ds_inst  (fs_to_ds_inst),
        .fs_to_ds_bd    (fs_to_ds_bd),
        .fs_to_ds_adel  (fs_to_ds_adel),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic bd,
                         input logic dok, input logic [31:0] rdata,
                         input logic dsa, input logic fl);
        pfs_to_fs_valid = pv;
        pfs_pc          = pc;
        pfs_bd          = bd;
        inst_data_ok    = dok;
        inst_rdata      = rdata;
        ds_allowin      = dsa;
        flush           = fl;
        #2;
    endtask

    task automatic idle(input logic dsa);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, dsa, 1'b0);
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] inst, input logic bd);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        e.bd   = bd;
        e.adel = (pc[1:0] != 2'b00);
        sb.push_back(e);
    endtask

    // Compare any ID handshake present this cycle, then advance one clock.
    task automatic step();
        exp_t e;
        if (fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'b0, fs_to_ds_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("out_pc",   fs_to_ds_pc,             e.pc);
                chk("out_inst", fs_to_ds_inst,           e.inst);
                chk("out_bd",   {31'b0, fs_to_ds_bd},    {31'b0, e.bd});
                chk("out_adel", {31'b0, fs_to_ds_adel},  {31'b0, e.adel});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle(1'b1);
        step();
        step();
        reset = 1'b0;
        idle(1'b1);
        chk("rst_allowin",  {31'b0, fs_allowin},     32'h1);
        chk("rst_valid",    {31'b0, fs_valid},       32'h0);
        chk("rst_to_ds",    {31'b0, fs_to_ds_valid}, 32'h0);
        step();

        // basic fetch with zero-latency pass-through
        drive(1'b1, 32'hbfc00000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_fetch(32'hbfc00000, 32'h24080001, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h24080001, 1'b1, 1'b0);
        chk("basic_to_ds", {31'b0, fs_to_ds_valid}, 32'h1);
        step();
        idle(1'b1);
        chk("basic_cleared", {31'b0, fs_valid}, 32'h0);
        step();

        // ID stall: response buffered until ID accepts
        drive(1'b1, 32'hbfc00004, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h8c090004, 1'b0, 1'b0);
        chk("stall_allowin", {31'b0, fs_allowin}, 32'h0);
        step();
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            chk("stall_hold", {31'b0, fs_allowin}, 32'h0);
            step();
        end
        expect_fetch(32'hbfc00004, 32'h8c090004, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'hdeadbeef, 1'b1, 1'b0);
        chk("stall_release", {31'b0, fs_allowin}, 32'h1);
        step();
        idle(1'b1);
        chk("stall_once", {31'b0, fs_to_ds_valid}, 32'h0);
        step();

        // flush with one outstanding fetch: next response is dropped
        drive(1'b1, 32'hbfc00010, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0);
        chk("flush1_drop", {31'b0, fs_to_ds_valid}, 32'h0);
        step();
        drive(1'b1, 32'hbfc00380, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_fetch(32'hbfc00380, 32'h3c1a8000, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h3c1a8000, 1'b1, 1'b0);
        chk("flush1_after", {31'b0, fs_to_ds_valid}, 32'h1);
        step();

        // flush with an outstanding fetch and a coincident request: two drops
        drive(1'b1, 32'hbfc00020, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hbfc00024, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'hbfc00100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush2_accept", {31'b0, fs_allowin}, 32'h1);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h22220000 + i, 1'b1, 1'b0);
            chk("flush2_drop", {31'b0, fs_to_ds_valid}, 32'h0);
            chk("flush2_wait", {31'b0, fs_allowin}, 32'h0);
            step();
        end
        expect_fetch(32'hbfc00100, 32'h00851021, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h00851021, 1'b1, 1'b0);
        chk("flush2_live", {31'b0, fs_to_ds_valid}, 32'h1);
        step();

        // unaligned PC and delay-slot flag
        drive(1'b1, 32'hbfc00002, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_fetch(32'hbfc00002, 32'h27bdfff8, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h27bdfff8, 1'b1, 1'b0);
        step();

        // reset while an instruction is buffered
        drive(1'b1, 32'hbfc00040, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        idle(1'b0);
        step();
        reset = 1'b0;
        idle(1'b1);
        chk("rst_buf_valid",   {31'b0, fs_valid},       32'h0);
        chk("rst_buf_allowin", {31'b0, fs_allowin},     32'h1);
        chk("rst_buf_to_ds",   {31'b0, fs_to_ds_valid}, 32'h0);
        step();

        // reset while a discard is pending: the next response must be live
        drive(1'b1, 32'hbfc00050, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step();
        reset = 1'b1;
        idle(1'b1);
        step();
        reset = 1'b0;
        drive(1'b1, 32'hbfc00060, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        expect_fetch(32'hbfc00060, 32'h2402000a, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2402000a, 1'b1, 1'b0);
        chk("rst_cnt_live", {31'b0, fs_to_ds_valid}, 32'h1);
        step();
        idle(1'b1);
        step();

        chk("sb_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
